axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

Single-outstanding AXI4-Lite master. It converts a simple command stream (write or read, address, data, strobe) into one AXI4-Lite transaction and returns the response on a result stream. It drives the slave side of the PL crossbar: a configuration sequencer or debug bridge uses it to reach the DMA, ad9361 and IIC register banks. A timeout counter detects a hung slave.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI and command address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT, 1024, maximum cycles a transaction may stay outstanding; 0 disables the timeout.

Ports:
- axi_aclk  in  1  sole clock.
- axi_areset  in  1  synchronous reset, active-high.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid / rsp_ready  out / in  1  result handshake.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  result was produced by the timeout.
- locked  out  1  sticky; a timeout occurred.
- m_axi_aw{valid,ready,addr,prot}, m_axi_w{valid,ready,data,strb}, m_axi_b{valid,ready,resp}  AXI4-Lite write channels.
- m_axi_ar{valid,ready,addr,prot}, m_axi_r{valid,ready,data,resp}  AXI4-Lite read channels.
- awprot and arprot are fixed at 3'b000.

## Operation
States:
- IDLE: cmd_ready = 1 when locked = 0 and axi_areset = 0. On cmd_valid & cmd_ready, capture the command, clear the timeout counter, and go to WR_REQ (cmd_wr = 1) or RD_REQ.
- WR_REQ: assert awvalid and wvalid together.
  - Each valid drops independently in the cycle after its own handshake.
  - Address and data stay stable while their valid is high.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, latch bresp, set rsp_rdata = 0, go to RSP.
- RD_REQ: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, latch rdata and rresp, go to RSP.
- RSP: rsp_valid = 1, outputs held stable. On rsp_ready, go to IDLE.

Timeout:
- The counter increments in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
- If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without the state's completing handshake:
  - Deassert all AXI valids and readies next cycle.
  - Go to RSP with rsp_resp = 2'b10, rsp_rdata = 0, rsp_timeout = 1.
  - Set locked = 1.
- While locked, cmd_ready stays 0 until reset, because the slave state is undefined after an abandoned transfer.
- If the handshake and the terminal count occur in the same cycle, the handshake wins: normal completion, no timeout.

Other rules:
- rsp_timeout = 0 on every normal completion.
- Only one transaction is outstanding at a time. No command is accepted until the result handshake completes.

## Timing
Reset:
- All m_axi valids and readies, rsp_valid, rsp_timeout and locked are 0.
- Captured address, data, strobe, rdata and resp registers are 0.
- cmd_ready is 0 during the reset cycle and 1 on the first cycle after it.

Command accepted at cycle N:
- awvalid/wvalid (write) or arvalid (read) are high at N+1.
- With a zero-wait slave: bready or rready high at N+2, response accepted at N+2, rsp_valid at N+3.
- Minimum command-to-result latency is 3 cycles. The next command can be accepted no earlier than the cycle after the rsp handshake.

Handshake rules:
- No valid depends combinationally on any ready.
- cmd_ready depends only on state, locked and axi_areset.

Timeout: valid or ready is held for exactly TIMEOUT cycles in the stalled state, then rsp_valid asserts the following cycle.

Reset in any state returns to IDLE next cycle and drops all valids immediately.

## Test plan
- Write, zero-wait slave: addr 0x41600000, data 0xDEADBEEF, strb 0xF.
  - awvalid/wvalid at N+1 carrying those values; bready at N+2.
  - rsp_valid at N+3 with rsp_resp = 00, rsp_rdata = 0, rsp_timeout = 0.
- Write, awready delayed 3 cycles, wready immediate:
  - wvalid high 1 cycle; awvalid held 4 cycles with stable address.
  - Exactly one result.
- Read, rvalid delayed 5 cycles with rdata 0x12345678, rsp_ready low for 2 cycles:
  - rsp_rdata = 0x12345678, rsp_valid held 3 cycles.
  - cmd_ready low until the rsp handshake.
- Write with bresp = 2'b10, then read with rresp = 2'b11:
  - Results 10 and 11 respectively, rsp_timeout = 0 for both, locked stays 0.
- TIMEOUT = 16, arready never asserted:
  - arvalid high for 16 cycles, then low.
  - rsp_valid with rsp_resp = 10, rsp_rdata = 0, rsp_timeout = 1.
  - locked = 1 and cmd_ready = 0 until axi_areset; after reset, locked = 0 and cmd_ready = 1.
- axi_areset asserted while awvalid is high and awready is low:
  - Next cycle all outputs are at reset values.
  - A new command after reset completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI4-Lite
// transaction and returns the response, with a hung-slave timeout that locks the block.
module axi_lite_cmd_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                      axi_aclk,
   input  logic                      axi_areset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_wr,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_timeout,
   output logic                      locked,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   input  logic [1:0]                m_axi_bresp,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp
);

   localparam int unsigned SW = DATA_WIDTH / 8;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_RSP     = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SW-1:0]         wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  to_q, to_d;
   logic                  locked_q, locked_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  expired;
   logic                  do_timeout;
   logic                  aw_done, w_done;

   assign cmd_ready = (state_q == S_IDLE) && !locked_q && !axi_areset;

   assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   // A valid already dropped means its handshake happened in an earlier cycle.
   assign aw_done = !awvalid_q || m_axi_awready;
   assign w_done  = !wvalid_q || m_axi_wready;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      rdata_d    = rdata_q;
      resp_d     = resp_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      arvalid_d  = arvalid_q;
      to_d       = to_q;
      locked_d   = locked_q;
      cnt_d      = cnt_q;
      do_timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               cnt_d   = '0;
               if (cmd_wr) begin
                  state_d   = S_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR_REQ: begin
            cnt_d     = cnt_q + CW'(1);
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q && !m_axi_wready;
            if (aw_done && w_done) state_d = S_WR_RESP;
            else if (expired)      do_timeout = 1'b1;
         end
         S_WR_RESP: begin
            cnt_d = cnt_q + CW'(1);
            if (m_axi_bvalid) begin
               resp_d  = m_axi_bresp;
               rdata_d = '0;
               to_d    = 1'b0;
               state_d = S_RSP;
            end else if (expired) begin
               do_timeout = 1'b1;
            end
         end
         S_RD_REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RD_DATA;
            end else if (expired) begin
               do_timeout = 1'b1;
            end
         end
         S_RD_DATA: begin
            cnt_d = cnt_q + CW'(1);
            if (m_axi_rvalid) begin
               rdata_d = m_axi_rdata;
               resp_d  = m_axi_rresp;
               to_d    = 1'b0;
               state_d = S_RSP;
            end else if (expired) begin
               do_timeout = 1'b1;
            end
         end
         S_RSP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (do_timeout) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         arvalid_d = 1'b0;
         resp_d    = 2'b10;
         rdata_d   = '0;
         to_d      = 1'b1;
         locked_d  = 1'b1;
         state_d   = S_RSP;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         to_q      <= 1'b0;
         locked_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         to_q      <= to_d;
         locked_q  <= locked_d;
         cnt_q     <= cnt_d;
      end
   end

   assign rsp_valid     = (state_q == S_RSP);
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign rsp_timeout   = to_q;
   assign locked        = locked_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = (state_q == S_WR_RESP);
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: the bench plays the AXI slave cycle by cycle
// and compares DUT outputs against hand-computed values.
module tb_axi_lite_cmd_master;

   logic        clk = 1'b0;
   logic        axi_areset;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout, locked;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [2:0]  awprot, arprot;
   logic [1:0]  bresp, rresp;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   axi_lite_cmd_master #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT   (16)
   ) dut (
      .axi_aclk     (clk),
      .axi_areset   (axi_areset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_wr       (cmd_wr),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .cmd_wstrb    (cmd_wstrb),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_resp     (rsp_resp),
      .rsp_timeout  (rsp_timeout),
      .locked       (locked),
      .m_axi_awvalid(awvalid),
      .m_axi_awready(awready),
      .m_axi_awaddr (awaddr),
      .m_axi_awprot (awprot),
      .m_axi_wvalid (wvalid),
      .m_axi_wready (wready),
      .m_axi_wdata  (wdata),
      .m_axi_wstrb  (wstrb),
      .m_axi_bvalid (bvalid),
      .m_axi_bready (bready),
      .m_axi_bresp  (bresp),
      .m_axi_arvalid(arvalid),
      .m_axi_arready(arready),
      .m_axi_araddr (araddr),
      .m_axi_arprot (arprot),
      .m_axi_rvalid (rvalid),
      .m_axi_rready (rready),
      .m_axi_rdata  (rdata),
      .m_axi_rresp  (rresp)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_idle();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
   endtask

   // Presents one command in IDLE; returns in the cycle after acceptance.
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      #1;
      chk("cmd_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int unsigned max);
      int unsigned n = 0;
      while (!rsp_valid && n < max) begin
         tick();
         n++;
      end
      chk("rsp_wait", rsp_valid, 1);
   endtask

   task automatic do_reset();
      axi_areset = 1'b1;
      #1;
      chk("cmd_ready_in_reset", cmd_ready, 0);
      tick();
      axi_areset = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned n;
      axi_areset = 1'b1;
      cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      slave_idle();
      tick();
      do_reset();

      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_rready", rready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_cmd_ready", cmd_ready, 1);

      // Zero-wait write
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      issue(1'b1, 32'h4160_0000, 32'hDEAD_BEEF, 4'hF);
      chk("w0_awvalid", awvalid, 1);
      chk("w0_wvalid", wvalid, 1);
      chk("w0_awaddr", awaddr, 32'h4160_0000);
      chk("w0_wdata", wdata, 32'hDEAD_BEEF);
      chk("w0_wstrb", wstrb, 4'hF);
      chk("w0_prot", {awprot, arprot}, 0);
      chk("w0_cmd_ready_busy", cmd_ready, 0);
      tick();
      chk("w0_awvalid_drop", awvalid, 0);
      chk("w0_bready", bready, 1);
      tick();
      chk("w0_rsp_valid", rsp_valid, 1);
      chk("w0_rsp_resp", rsp_resp, 2'b00);
      chk("w0_rsp_rdata", rsp_rdata, 0);
      chk("w0_rsp_timeout", rsp_timeout, 0);
      chk("w0_bready_drop", bready, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      slave_idle();
      chk("w0_rsp_done", rsp_valid, 0);
      chk("w0_cmd_ready_again", cmd_ready, 1);

      // Write with awready delayed 3 cycles
      wready = 1'b1;
      issue(1'b1, 32'h4160_0010, 32'h0000_00A5, 4'h1);
      for (int i = 0; i < 4; i++) begin
         chk("w1_awvalid_held", awvalid, 1);
         chk("w1_awaddr_stable", awaddr, 32'h4160_0010);
         chk("w1_wvalid", wvalid, (i == 0) ? 1 : 0);
         if (i == 3) awready = 1'b1;
         tick();
      end
      chk("w1_awvalid_drop", awvalid, 0);
      chk("w1_bready", bready, 1);
      bvalid = 1'b1;
      tick();
      slave_idle();
      chk("w1_rsp_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) n++;
         tick();
      end
      chk("w1_single_result", n, 0);

      // Read with rvalid delayed 5 cycles and rsp back-pressure
      arready = 1'b1;
      issue(1'b0, 32'h7940_0004, 32'h0, 4'h0);
      chk("r0_arvalid", arvalid, 1);
      chk("r0_araddr", araddr, 32'h7940_0004);
      tick();
      arready = 1'b0;
      chk("r0_arvalid_drop", arvalid, 0);
      for (int i = 0; i < 5; i++) begin
         chk("r0_rready", rready, 1);
         chk("r0_no_rsp", rsp_valid, 0);
         tick();
      end
      rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
      chk("r0_rready_last", rready, 1);
      tick();
      slave_idle();
      for (int i = 0; i < 3; i++) begin
         chk("r0_rsp_valid", rsp_valid, 1);
         chk("r0_rsp_rdata", rsp_rdata, 32'h1234_5678);
         chk("r0_rsp_resp", rsp_resp, 2'b00);
         chk("r0_cmd_ready_blocked", cmd_ready, 0);
         if (i == 2) rsp_ready = 1'b1;
         tick();
      end
      rsp_ready = 1'b0;
      chk("r0_rsp_done", rsp_valid, 0);
      chk("r0_cmd_ready_again", cmd_ready, 1);

      // Error responses pass through
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
      issue(1'b1, 32'h4160_0020, 32'h1, 4'hF);
      wait_rsp(8);
      chk("e0_bresp", rsp_resp, 2'b10);
      chk("e0_timeout", rsp_timeout, 0);
      chk("e0_rdata", rsp_rdata, 0);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      slave_idle();
      arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b11;
      issue(1'b0, 32'h4160_0024, 32'h0, 4'h0);
      wait_rsp(8);
      chk("e1_rresp", rsp_resp, 2'b11);
      chk("e1_rdata", rsp_rdata, 32'hCAFE_0001);
      chk("e1_timeout", rsp_timeout, 0);
      chk("e1_locked", locked, 0);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      slave_idle();

      // Timeout: arready never asserted
      issue(1'b0, 32'h4160_0030, 32'h0, 4'h0);
      n = 0;
      while (arvalid && n < 40) begin
         n++;
         tick();
      end
      chk("to_arvalid_cycles", n, 16);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_resp", rsp_resp, 2'b10);
      chk("to_rsp_rdata", rsp_rdata, 0);
      chk("to_rsp_timeout", rsp_timeout, 1);
      chk("to_locked", locked, 1);
      chk("to_rready", rready, 0);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      chk("to_rsp_done", rsp_valid, 0);
      tick(); tick();
      chk("to_cmd_ready_locked", cmd_ready, 0);
      chk("to_locked_sticky", locked, 1);
      do_reset();
      chk("to_locked_cleared", locked, 0);
      chk("to_cmd_ready_after_rst", cmd_ready, 1);
      chk("to_rsp_timeout_cleared", rsp_timeout, 0);

      // Reset during a stalled write address phase
      issue(1'b1, 32'h4160_0040, 32'h5555_AAAA, 4'h3);
      chk("rs_awvalid", awvalid, 1);
      tick();
      chk("rs_awvalid_still", awvalid, 1);
      do_reset();
      chk("rs_awvalid_clr", awvalid, 0);
      chk("rs_wvalid_clr", wvalid, 0);
      chk("rs_bready_clr", bready, 0);
      chk("rs_rsp_valid_clr", rsp_valid, 0);
      chk("rs_awaddr_clr", awaddr, 0);
      chk("rs_wdata_clr", wdata, 0);
      chk("rs_cmd_ready", cmd_ready, 1);
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      issue(1'b1, 32'h4160_0044, 32'h0BAD_F00D, 4'hF);
      chk("rs_new_awaddr", awaddr, 32'h4160_0044);
      wait_rsp(8);
      chk("rs_new_resp", rsp_resp, 2'b00);
      chk("rs_new_timeout", rsp_timeout, 0);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      slave_idle();
      chk("rs_new_done", cmd_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
